// File: rtl/led_level_meter.sv
// Eight-channel peak-hold level meter: reduces each sample to 8 bits, holds the signed peak per channel, decays it slowly.
// Latency: strobe accepted in cycle N -> led0..led7 and frame_done valid in cycle N+9 (8 SCAN cycles + COMMIT).
// Backpressure: none; a strobe arriving during SCAN/COMMIT is dropped and flagged with a same-cycle overrun pulse.
// Optional: define LED_LEVEL_METER_JACK_MASK_EN to blank channels whose jack flag is low.
module led_level_meter #(
  parameter int W            = 16,
  parameter int DECAY_FRAMES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic signed [W-1:0] sample0,
  input  logic signed [W-1:0] sample1,
  input  logic signed [W-1:0] sample2,
  input  logic signed [W-1:0] sample3,
  input  logic signed [W-1:0] sample4,
  input  logic signed [W-1:0] sample5,
  input  logic signed [W-1:0] sample6,
  input  logic signed [W-1:0] sample7,
  input  logic [7:0]          jack,
  output logic signed [7:0]   led0,
  output logic signed [7:0]   led1,
  output logic signed [7:0]   led2,
  output logic signed [7:0]   led3,
  output logic signed [7:0]   led4,
  output logic signed [7:0]   led5,
  output logic signed [7:0]   led6,
  output logic signed [7:0]   led7,
  output logic                frame_done,
  output logic                overrun
);

  // Frame counter is at least one bit wide so DECAY_FRAMES = 1 still elaborates.
  localparam int            CW      = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [CW-1:0] FC_LAST = CW'(DECAY_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t             state;
  logic [2:0]         idx;
  logic [CW-1:0]      fcnt;
  logic signed [7:0]  samp8 [8];
  logic [6:0]         hm [8];
  logic [7:0]         hs;
  logic signed [7:0]  led_r [8];

  logic signed [7:0]  s8;
  logic [6:0]         m;
  logic               tick;
  logic [6:0]         hm_nx [8];
  logic [7:0]         hs_nx;

  // Only the top 8 bits of each sample matter; the low bits are intentionally dropped.
  generate
    if (W > 8) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^{sample0[W-9:0], sample1[W-9:0], sample2[W-9:0], sample3[W-9:0],
                                 sample4[W-9:0], sample5[W-9:0], sample6[W-9:0], sample7[W-9:0]};
    end
  endgenerate

`ifndef LED_LEVEL_METER_JACK_MASK_EN
  logic unused_jack;
  assign unused_jack = ^jack;
`endif

  assign tick    = (fcnt == FC_LAST);
  assign overrun = sample_valid && (state != IDLE) && !rst;

  assign led0 = led_r[0];
  assign led1 = led_r[1];
  assign led2 = led_r[2];
  assign led3 = led_r[3];
  assign led4 = led_r[4];
  assign led5 = led_r[5];
  assign led6 = led_r[6];
  assign led7 = led_r[7];

  // Signed LED value from a held magnitude and sign; zero magnitude gives 0 for either sign.
  function automatic logic signed [7:0] led_val(input logic [6:0] mag, input logic neg);
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  // Magnitude of the channel under scan, with -128 saturated to 127.
  always_comb begin
    s8 = samp8[idx];
    if (s8 == -8'sd128) m = 7'd127;
    else if (s8[7])     m = 7'(~s8[6:0] + 7'd1);
    else                m = s8[6:0];
  end

  // Next peak-hold state: only the channel under scan can change.
  always_comb begin
    hm_nx = hm;
    hs_nx = hs;
    if (state == SCAN) begin
`ifdef LED_LEVEL_METER_JACK_MASK_EN
      if (!jack[idx]) begin
        hm_nx[idx] = 7'd0;
        hs_nx[idx] = 1'b0;
      end else
`endif
      if (m >= hm[idx]) begin
        hm_nx[idx] = m;
        hs_nx[idx] = s8[7];
      end else if (tick && (hm[idx] != 7'd0)) begin
        hm_nx[idx] = hm[idx] - 7'd1;
      end
    end
  end

  // Frame sequencer; LEDs load from the post-update hold so channel 7 is current at COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      fcnt       <= '0;
      hs         <= 8'd0;
      frame_done <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        samp8[n] <= 8'sd0;
        hm[n]    <= 7'd0;
        led_r[n] <= 8'sd0;
      end
    end else begin
      frame_done <= 1'b0;
      hm         <= hm_nx;
      hs         <= hs_nx;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            samp8[0] <= sample0[W-1 -: 8];
            samp8[1] <= sample1[W-1 -: 8];
            samp8[2] <= sample2[W-1 -: 8];
            samp8[3] <= sample3[W-1 -: 8];
            samp8[4] <= sample4[W-1 -: 8];
            samp8[5] <= sample5[W-1 -: 8];
            samp8[6] <= sample6[W-1 -: 8];
            samp8[7] <= sample7[W-1 -: 8];
            idx      <= 3'd0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            state      <= COMMIT;
            frame_done <= 1'b1;
            for (int n = 0; n < 8; n++) led_r[n] <= led_val(hm_nx[n], hs_nx[n]);
          end
        end
        COMMIT: begin
          state <= IDLE;
          fcnt  <= (fcnt == FC_LAST) ? '0 : fcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_level_meter.sv
// Directed bench for led_level_meter with DECAY_FRAMES = 4.
// Table of whole-frame vectors followed by overrun, mid-frame reset, decay and jack sequences.
module tb_led_level_meter;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_valid = 1'b0;
  logic [7:0][15:0]  smp = '0;
  logic [7:0]        jack = 8'hFF;
  logic signed [7:0] led0, led1, led2, led3, led4, led5, led6, led7;
  logic              frame_done, overrun;
  logic [7:0][7:0]   leds;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string           name;
    logic [7:0][15:0] s;
    logic [7:0][7:0]  led;
  } vec_t;
  vec_t tbl[$];

  assign leds = {led7, led6, led5, led4, led3, led2, led1, led0};

  always #5 clk = ~clk;

  led_level_meter #(.W(16), .DECAY_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .sample0(smp[0]), .sample1(smp[1]), .sample2(smp[2]), .sample3(smp[3]),
    .sample4(smp[4]), .sample5(smp[5]), .sample6(smp[6]), .sample7(smp[7]),
    .jack(jack),
    .led0(led0), .led1(led1), .led2(led2), .led3(led3),
    .led4(led4), .led5(led5), .led6(led6), .led7(led7),
    .frame_done(frame_done), .overrun(overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [7:0][15:0] s, input logic [7:0][7:0] l);
    vec_t v;
    v.name = name;
    v.s    = s;
    v.led  = l;
    tbl.push_back(v);
  endtask

  // Strobe once, then wait (bounded) for frame_done; leaves the bench in the COMMIT cycle.
  task automatic run_frame(input string name);
    int lat;
    @(negedge clk); sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0; lat = 1;
    while (frame_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, " frame_done latency"}, lat, 9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int done_at;
    logic [7:0][7:0] exp_l;
    logic [7:0] e0;

    // Frames counted from reset; ticks land on frames 4, 8, ...
    add("f1 s0=4000",        {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000},
                             {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40});
    add("f2 s3=8000",        {16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0},
                             {8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h40});
    add("f3 s3=FF00 hold",   {16'h0, 16'hC000, 16'h3FFF, 16'h0, 16'hFF00, 16'h0, 16'h0, 16'h0},
                             {8'h00, 8'hC0, 8'h3F, 8'h00, 8'h81, 8'h00, 8'h00, 8'h40});
    add("f4 decay tick",     {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0},
                             {8'h00, 8'hC1, 8'h3E, 8'h00, 8'h82, 8'h00, 8'h01, 8'h3F});
    add("f5 full scale",     {16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h80FF, 16'h0, 16'h0},
                             {8'h7F, 8'hC1, 8'h3E, 8'h00, 8'h82, 8'h81, 8'h01, 8'h3F});
    add("f6 equal/sign flip",{16'h0, 16'h4100, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFF80, 16'h0},
                             {8'h7F, 8'h41, 8'h3E, 8'h00, 8'h82, 8'h81, 8'hFF, 8'h3F});

    // Reset state
    #12;
    check("reset leds", leds, 64'h0);
    check("reset frame_done", frame_done, 1'b0);
    check("reset overrun", overrun, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Table-driven frames, back to back at minimum spacing
    foreach (tbl[i]) begin
      smp = tbl[i].s;
      run_frame(tbl[i].name);
      for (int n = 0; n < 8; n++)
        check($sformatf("%s led%0d", tbl[i].name, n), leds[n], tbl[i].led[n]);
    end
    @(negedge clk);
    check("frame_done single cycle", frame_done, 1'b0);
    check("leds stable after COMMIT", leds, {8'h7F, 8'h41, 8'h3E, 8'h00, 8'h82, 8'h81, 8'hFF, 8'h3F});

    // Overrun: second strobe in cycle N+3 is dropped, first frame's data wins
    smp = '0; smp[4] = 16'h5000;
    @(negedge clk); sample_valid = 1'b1; #1;
    check("no overrun on accepted strobe", overrun, 1'b0);
    @(negedge clk); sample_valid = 1'b0;
    n_done = 0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        smp[4] = 16'h7F00; sample_valid = 1'b1; #1;
        check("overrun pulse", overrun, 1'b1);
      end else if (c == 4) begin
        sample_valid = 1'b0; #1;
        check("overrun one cycle", overrun, 1'b0);
      end
      if (frame_done === 1'b1) begin
        n_done++;
        done_at = c;
      end
      @(negedge clk);
    end
    check("overrun frame_done count", n_done, 1);
    check("overrun frame_done cycle", done_at, 9);
    exp_l = {8'h7F, 8'h41, 8'h3E, 8'h50, 8'h82, 8'h81, 8'hFF, 8'h3F};
    for (int n = 0; n < 8; n++)
      check($sformatf("overrun led%0d", n), leds[n], exp_l[n]);

    // Reset while channel 4 is being scanned
    smp = '0; smp[2] = 16'h1000;
    @(negedge clk); sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; #1;
    check("mid-scan reset leds", leds, 64'h0);
    check("mid-scan reset frame_done", frame_done, 1'b0);
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (frame_done === 1'b1) n_done++;
    end
    check("no frame_done after reset", n_done, 0);
    check("leds still 0 after reset", leds, 64'h0);

    // Decay: +10 held, then zero frames; one step every 4th frame down to 0
    smp = '0; smp[0] = 16'h0A00;
    run_frame("decay f1");
    check("decay f1 leds", leds, 64'h0A);
    smp = '0;
    for (int f = 2; f <= 48; f++) begin
      run_frame($sformatf("decay f%0d", f));
      e0 = (f / 4 >= 10) ? 8'd0 : 8'(10 - f / 4);
      check($sformatf("decay f%0d led0", f), leds[0], e0);
    end

`ifdef LED_LEVEL_METER_JACK_MASK_EN
    jack = 8'hFE; smp = '0; smp[0] = 16'h7FFF;
    run_frame("jack out");
    check("jack out led0", leds[0], 8'h00);
    jack = 8'hFF;
    run_frame("jack in");
    check("jack in led0", leds[0], 8'h7F);
`else
    jack = 8'hFE; smp = '0; smp[0] = 16'h7FFF;
    run_frame("jack ignored");
    check("jack ignored led0", leds[0], 8'h7F);
    jack = 8'hFF;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_level_meter.md
LED_LEVEL_METER -- requirements
Module: led_level_meter

Interface
REQ-001 SHALL have parameter W, default 16, sample width in bits (W >= 8).
REQ-002 SHALL have parameter DECAY_FRAMES, default 256, accepted frames per 1-step decay of held level (>= 1).
REQ-003 SHALL have ports:
- clk  in  1  system clock; sole clock.
- rst  in  1  reset; asynchronous, active-high.
- sample_valid  in  1  one-cycle strobe; sample0..sample7 valid.
- sample0..sample7  in  W each, signed  per-channel audio samples.
- jack  in  8  jack-inserted flags, bit n = channel n (used only under REQ-019).
- led0..led7  out  8 each, signed  LED drive values for the I2C LED stage.
- frame_done  out  1  one-cycle pulse when led0..led7 update.
- overrun  out  1  one-cycle pulse when a strobe is dropped.

Function
REQ-004 SHALL implement FSM states IDLE, SCAN, COMMIT.
- IDLE -> SCAN on sample_valid.
- SCAN -> COMMIT after channel index 7.
- COMMIT -> IDLE unconditionally.
REQ-005 SHALL latch all eight samples in the IDLE cycle where sample_valid is high, then set channel index to 0.
REQ-006 SHALL process one channel per SCAN cycle, index 0..7, so SCAN lasts exactly 8 cycles.
REQ-007 SHALL reduce each sample to s8 = arithmetic shift right by W-8 (top 8 bits, sign kept).
REQ-008 SHALL set magnitude m = |s8|, saturated so s8 = -128 gives m = 127; m range 0..127.
REQ-009 SHALL hold per channel a 7-bit magnitude hm[n] and a sign bit hs[n].
REQ-010 SHALL update hold per channel as:
- if m >= hm[n]: hm[n] <= m, hs[n] <= sign of s8;
- else if decay tick active: hm[n] <= hm[n] - 1, never below 0;
- else: hold unchanged.
REQ-011 SHALL keep a frame counter 0..DECAY_FRAMES-1, advanced once per accepted frame, wrapping to 0.
- Decay tick is active for the whole SCAN of the frame where the counter is DECAY_FRAMES-1.
- DECAY_FRAMES = 1 gives a tick every frame.
REQ-012 SHALL, in COMMIT, load every led[n] with hs[n] ? -hm[n] : +hm[n]; led values lie in -127..+127, and hm = 0 gives 0 whatever the sign.
REQ-013 SHALL leave led0..led7 unchanged in every cycle other than COMMIT.
REQ-014 SHALL assert frame_done for exactly the COMMIT cycle, so frame_done is high on cycle N+9 after a strobe accepted in cycle N.
REQ-015 SHALL drop a sample_valid seen in SCAN or COMMIT, without changing latched samples or hold state, and pulse overrun in that same cycle.
REQ-016 SHALL accept a strobe in the first IDLE cycle after COMMIT (10-cycle minimum frame spacing).

Reset
REQ-017 SHALL, while rst is high and independent of clk:
- force state IDLE, channel index 0, frame counter 0;
- clear all hm and hs;
- drive led0..led7 = 0, frame_done = 0, overrun = 0.
REQ-018 SHALL discard any frame in progress when rst asserts mid-SCAN/COMMIT, with no COMMIT and no frame_done after reset release.

Configuration
REQ-019 SHALL support macro LED_LEVEL_METER_JACK_MASK_EN.
- When defined: a channel whose jack bit is 0 during its SCAN cycle has m forced to 0 and hm[n], hs[n] cleared immediately, so its LED shows 0 at the next COMMIT.
- When undefined: jack is ignored, no logic depends on it, and all channels follow REQ-010.

Verification
REQ-020 SHALL cover: reset then sample0 = 16'h4000, rest 0, one strobe -> frame_done 9 cycles later, led0 = +64, others 0.
REQ-021 SHALL cover: sample3 = 16'h8000 -> led3 = -127; then sample3 = 16'hFF00 (s8 = -1) -> led3 stays -127 until decay.
REQ-022 SHALL cover: DECAY_FRAMES = 4, led0 held at +10, zero samples -> led0 decrements by 1 every 4th frame_done, reaches 0 and stays 0.
REQ-023 SHALL cover: second strobe 3 cycles after the first -> overrun pulse in that cycle, one frame_done only, outputs reflect the first frame.
REQ-024 SHALL cover: rst asserted at SCAN channel 4 -> all led 0 at once, no frame_done after release, next strobe processed normally.
REQ-025 SHALL cover, with LED_LEVEL_METER_JACK_MASK_EN: jack = 8'hFE, sample0 = 16'h7FFF -> led0 = 0; jack = 8'hFF -> led0 = +127.
